pop_pulse_sequencer: RTL and testbench

// - Generates the pulsed-optical-pumping (POP) timing cycle: PUMP -> DARK -> PROBE -> GAP.
// - Drives registered pump/probe gate outputs, with phase lengths programmable in clock cycles.
// - Sits directly downstream of the clocks block and runs entirely on its internal-oscillator

---
 rtl/pop_pulse_sequencer_if.sv | 30 +++
 rtl/pop_pulse_sequencer.sv | 149 ++++++++++++++
 tb/tb_pop_pulse_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/pop_pulse_sequencer_if.sv
// Control/status bundle for the POP pulse sequencer: start/stop/length inputs,
// gate and status outputs. The sequencer uses the slave view.
interface pop_pulse_sequencer_if #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 16
);
    logic             start;
    logic             stop;
    logic             continuous;
    logic [CNT_W-1:0] pump_len;
    logic [CNT_W-1:0] dark_len;
    logic [CNT_W-1:0] probe_len;
    logic [CNT_W-1:0] gap_len;
    logic             pump_gate;
    logic             probe_gate;
    logic             cycle_sync;
    logic             busy;
    logic             done;
    logic [CYC_W-1:0] cycle_count;

    modport master (
        output start, stop, continuous, pump_len, dark_len, probe_len, gap_len,
        input  pump_gate, probe_gate, cycle_sync, busy, done, cycle_count
    );

    modport slave (
        input  start, stop, continuous, pump_len, dark_len, probe_len, gap_len,
        output pump_gate, probe_gate, cycle_sync, busy, done, cycle_count
    );
endinterface

// File: rtl/pop_pulse_sequencer.sv
// Pulsed-optical-pumping timing sequencer: PUMP -> DARK -> PROBE -> GAP with
// programmable phase lengths, single-shot/continuous modes, abort and cycle count.
module pop_pulse_sequencer #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 16
) (
    input  logic                  clk_2M5,
    input  logic                  rst_n,
    pop_pulse_sequencer_if.slave  seq
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_PUMP,
        S_DARK,
        S_PROBE,
        S_GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] pump_q, dark_q, probe_q, gap_q;
    logic             pump_gate_q, probe_gate_q, cycle_sync_q, busy_q, done_q;
    logic [CYC_W-1:0] cycle_count_q;

    state_t           after;     // next nonzero phase within the running cycle
    state_t           first_in;  // first nonzero phase of the live length inputs
    state_t           tgt;
    logic [CNT_W-1:0] tgt_len;
    logic             use_in;

    function automatic logic [CNT_W-1:0] phase_len(
        input state_t ph,
        input logic [CNT_W-1:0] p, d, r, g
    );
        case (ph)
            S_PUMP:  return p;
            S_DARK:  return d;
            S_PROBE: return r;
            S_GAP:   return g;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        after = S_IDLE;
        case (state)
            S_PUMP: begin
                if (dark_q != '0)       after = S_DARK;
                else if (probe_q != '0) after = S_PROBE;
                else if (gap_q != '0)   after = S_GAP;
            end
            S_DARK: begin
                if (probe_q != '0)      after = S_PROBE;
                else if (gap_q != '0)   after = S_GAP;
            end
            S_PROBE: begin
                if (gap_q != '0)        after = S_GAP;
            end
            default: after = S_IDLE;
        endcase

        first_in = S_IDLE;
        if (seq.pump_len != '0)       first_in = S_PUMP;
        else if (seq.dark_len != '0)  first_in = S_DARK;
        else if (seq.probe_len != '0) first_in = S_PROBE;
        else if (seq.gap_len != '0)   first_in = S_GAP;

        // A new cycle (from IDLE or after the last phase) draws on the inputs,
        // a phase change inside a cycle draws on the latched lengths.
        use_in  = (state == S_IDLE) || (after == S_IDLE);
        tgt     = use_in ? first_in : after;
        tgt_len = use_in ? phase_len(tgt, seq.pump_len, seq.dark_len, seq.probe_len, seq.gap_len)
                         : phase_len(tgt, pump_q, dark_q, probe_q, gap_q);
    end

    always_ff @(posedge clk_2M5 or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            cnt           <= '0;
            pump_q        <= '0;
            dark_q        <= '0;
            probe_q       <= '0;
            gap_q         <= '0;
            pump_gate_q   <= 1'b0;
            probe_gate_q  <= 1'b0;
            cycle_sync_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            cycle_count_q <= '0;
        end else begin
            cycle_sync_q <= 1'b0;
            done_q       <= 1'b0;
            if (state == S_IDLE) begin
                if (seq.start && !seq.stop && (first_in != S_IDLE)) begin
                    state         <= tgt;
                    cnt           <= tgt_len - 1'b1;
                    pump_q        <= seq.pump_len;
                    dark_q        <= seq.dark_len;
                    probe_q       <= seq.probe_len;
                    gap_q         <= seq.gap_len;
                    cycle_count_q <= '0;
                    pump_gate_q   <= (tgt == S_PUMP);
                    probe_gate_q  <= (tgt == S_PROBE);
                    busy_q        <= 1'b1;
                    cycle_sync_q  <= 1'b1;
                end
            end else if (seq.stop) begin
                state        <= S_IDLE;
                pump_gate_q  <= 1'b0;
                probe_gate_q <= 1'b0;
                busy_q       <= 1'b0;
            end else if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else if (after != S_IDLE) begin
                state        <= tgt;
                cnt          <= tgt_len - 1'b1;
                pump_gate_q  <= (tgt == S_PUMP);
                probe_gate_q <= (tgt == S_PROBE);
            end else begin
                if (cycle_count_q != '1)
                    cycle_count_q <= cycle_count_q + 1'b1;
                if (seq.continuous && (first_in != S_IDLE)) begin
                    state        <= tgt;
                    cnt          <= tgt_len - 1'b1;
                    pump_q       <= seq.pump_len;
                    dark_q       <= seq.dark_len;
                    probe_q      <= seq.probe_len;
                    gap_q        <= seq.gap_len;
                    pump_gate_q  <= (tgt == S_PUMP);
                    probe_gate_q <= (tgt == S_PROBE);
                    cycle_sync_q <= 1'b1;
                end else begin
                    state        <= S_IDLE;
                    pump_gate_q  <= 1'b0;
                    probe_gate_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                end
            end
        end
    end

    assign seq.pump_gate   = pump_gate_q;
    assign seq.probe_gate  = probe_gate_q;
    assign seq.cycle_sync  = cycle_sync_q;
    assign seq.busy        = busy_q;
    assign seq.done        = done_q;
    assign seq.cycle_count = cycle_count_q;
endmodule

// File: tb/tb_pop_pulse_sequencer.sv
// Scoreboard bench for pop_pulse_sequencer: a slot-queue reference model predicts
// every cycle's outputs; a monitor compares two instances (16-bit and 4-bit counters).
module tb_pop_pulse_sequencer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        continuous = 1'b0;
    logic [15:0] pump_len = '0;
    logic [15:0] dark_len = '0;
    logic [15:0] probe_len = '0;
    logic [15:0] gap_len = '0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pop_pulse_sequencer_if #(.CNT_W(16), .CYC_W(16)) bus_a ();
    pop_pulse_sequencer_if #(.CNT_W(16), .CYC_W(4))  bus_b ();

    assign bus_a.start = start;      assign bus_b.start = start;
    assign bus_a.stop = stop;        assign bus_b.stop = stop;
    assign bus_a.continuous = continuous; assign bus_b.continuous = continuous;
    assign bus_a.pump_len = pump_len;     assign bus_b.pump_len = pump_len;
    assign bus_a.dark_len = dark_len;     assign bus_b.dark_len = dark_len;
    assign bus_a.probe_len = probe_len;   assign bus_b.probe_len = probe_len;
    assign bus_a.gap_len = gap_len;       assign bus_b.gap_len = gap_len;

    pop_pulse_sequencer #(.CNT_W(16), .CYC_W(16)) u_a (
        .clk_2M5 (clk),
        .rst_n   (rst_n),
        .seq     (bus_a.slave)
    );

    pop_pulse_sequencer #(.CNT_W(16), .CYC_W(4)) u_b (
        .clk_2M5 (clk),
        .rst_n   (rst_n),
        .seq     (bus_b.slave)
    );

    // Reference model: a running cycle is a queue of per-cycle phase labels.
    typedef struct {
        bit          pg, qg, sy, bs, dn;
        logic [15:0] cc16;
        logic [3:0]  cc4;
    } exp_t;

    exp_t        exp_q[$];
    int          slots[$];
    bit          m_busy = 1'b0;
    bit          m_sync = 1'b0;
    bit          m_done = 1'b0;
    logic [15:0] m_cnt16 = '0;
    logic [3:0]  m_cnt4 = '0;

    function automatic bit any_len();
        return (pump_len != 0) || (dark_len != 0) || (probe_len != 0) || (gap_len != 0);
    endfunction

    function automatic void expand();
        slots.delete();
        for (int i = 0; i < int'(pump_len); i++)  slots.push_back(1);
        for (int i = 0; i < int'(dark_len); i++)  slots.push_back(2);
        for (int i = 0; i < int'(probe_len); i++) slots.push_back(3);
        for (int i = 0; i < int'(gap_len); i++)   slots.push_back(4);
    endfunction

    always @(posedge clk) begin
        exp_t e;
        if (!rst_n) begin
            slots.delete();
            m_busy = 0; m_sync = 0; m_done = 0; m_cnt16 = '0; m_cnt4 = '0;
        end else begin
            m_sync = 0;
            m_done = 0;
            if (!m_busy) begin
                if (start && !stop && any_len()) begin
                    expand();
                    m_cnt16 = '0; m_cnt4 = '0;
                    m_sync = 1; m_busy = 1;
                end
            end else if (stop) begin
                slots.delete();
                m_busy = 0;
            end else begin
                void'(slots.pop_front());
                if (slots.size() == 0) begin
                    if (m_cnt16 != 16'hFFFF) m_cnt16 = m_cnt16 + 1'b1;
                    if (m_cnt4 != 4'hF)      m_cnt4 = m_cnt4 + 1'b1;
                    if (continuous && any_len()) begin
                        expand();
                        m_sync = 1;
                    end else begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
        end
        e.pg   = m_busy && (slots.size() > 0) && (slots[0] == 1);
        e.qg   = m_busy && (slots.size() > 0) && (slots[0] == 3);
        e.sy   = m_sync;
        e.bs   = m_busy;
        e.dn   = m_done;
        e.cc16 = m_cnt16;
        e.cc4  = m_cnt4;
        exp_q.push_back(e);
    end

    // Monitor: outputs are valid every cycle; compare on the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_tests++;
            if ({bus_a.pump_gate, bus_a.probe_gate, bus_a.cycle_sync, bus_a.busy, bus_a.done} !==
                    {e.pg, e.qg, e.sy, e.bs, e.dn} || bus_a.cycle_count !== e.cc16) begin
                n_fail++;
                $display("FAIL dut16 t=%0t got pg%b qg%b sy%b bs%b dn%b cc%0d want pg%b qg%b sy%b bs%b dn%b cc%0d",
                         $time, bus_a.pump_gate, bus_a.probe_gate, bus_a.cycle_sync, bus_a.busy,
                         bus_a.done, bus_a.cycle_count, e.pg, e.qg, e.sy, e.bs, e.dn, e.cc16);
            end
            n_tests++;
            if ({bus_b.pump_gate, bus_b.probe_gate, bus_b.cycle_sync, bus_b.busy, bus_b.done} !==
                    {e.pg, e.qg, e.sy, e.bs, e.dn} || bus_b.cycle_count !== e.cc4) begin
                n_fail++;
                $display("FAIL dut4 t=%0t got pg%b qg%b sy%b bs%b dn%b cc%0d want pg%b qg%b sy%b bs%b dn%b cc%0d",
                         $time, bus_b.pump_gate, bus_b.probe_gate, bus_b.cycle_sync, bus_b.busy,
                         bus_b.done, bus_b.cycle_count, e.pg, e.qg, e.sy, e.bs, e.dn, e.cc4);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_len(input int p, input int d, input int r, input int g);
        pump_len = 16'(p); dark_len = 16'(d); probe_len = 16'(r); gap_len = 16'(g);
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1; tick(1); stop = 1'b0;
    endtask

    task automatic check_zero(input string name, input logic got);
        n_tests++;
        if (got !== 1'b0) begin
            n_fail++;
            $display("FAIL %s got %b want 0", name, got);
        end
    endtask

    initial begin
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // single shot 3/2/4/1
        set_len(3, 2, 4, 1); continuous = 1'b0;
        pulse_start(); tick(14);

        // continuous 2/1/2/1, five periods, then abort
        set_len(2, 1, 2, 1); continuous = 1'b1;
        pulse_start(); tick(29);
        pulse_stop(); tick(3);

        // zero-length skip and all-zero start
        set_len(0, 0, 3, 0); continuous = 1'b0;
        pulse_start(); tick(6);
        set_len(0, 0, 0, 0);
        pulse_start(); tick(3);

        // start while busy, start+stop together, stop while busy
        set_len(3, 2, 4, 1);
        pulse_start(); tick(2); pulse_start(); tick(12);
        start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0; tick(3);
        pulse_start(); tick(4); pulse_stop(); tick(3);

        // lengths changed mid-cycle only affect the next continuous cycle
        set_len(2, 1, 2, 1); continuous = 1'b1;
        pulse_start(); tick(3); set_len(1, 1, 1, 1); tick(12);
        pulse_stop(); tick(3);

        // async reset in the middle of PROBE
        set_len(3, 2, 4, 1); continuous = 1'b0;
        pulse_start(); tick(6);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_zero("rst_probe_gate16", bus_a.probe_gate);
        check_zero("rst_busy16", bus_a.busy);
        check_zero("rst_probe_gate4", bus_b.probe_gate);
        check_zero("rst_busy4", bus_b.busy);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        tick(1);
        pulse_start(); tick(13);

        // counter saturation on the 4-bit instance
        set_len(1, 0, 0, 0); continuous = 1'b1;
        pulse_start(); tick(20);
        pulse_stop(); tick(2);

        // randomized operation
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0)
                set_len($urandom_range(0, 3), $urandom_range(0, 3),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            continuous = ($urandom_range(0, 3) != 0);
            start      = ($urandom_range(0, 5) == 0);
            stop       = ($urandom_range(0, 39) == 0);
            tick(1);
        end
        start = 1'b0;
        stop  = 1'b1; tick(1); stop = 1'b0;
        tick(4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
